// File: rtl/elementwise_operand_fetch_pkg.sv
// Shared definitions for the element-wise operand fetch block and its ALU
// consumer: bus widths, element-op codes and the latched command payload.
package elementwise_operand_fetch_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned ADDR_WIDTH = 12;
  localparam int unsigned LEN_WIDTH  = 12;
  localparam int unsigned OP_WIDTH   = 3;

  // Element-op codes understood by the ALU stage
  typedef enum logic [OP_WIDTH-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_MAX = 3'd3,
    OP_MIN = 3'd4,
    OP_AND = 3'd5,
    OP_OR  = 3'd6,
    OP_NOT = 3'd7
  } elem_op_e;

  // Command fields captured at accept
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [LEN_WIDTH-1:0]  len;
    logic [OP_WIDTH-1:0]   op;
    logic                  bcast_b;
  } fetch_cmd_t;

endpackage

// File: rtl/elementwise_operand_fetch_if.sv
// Bus bundle for the operand fetch block: command channel, scratchpad read
// port and the operand-pair channel toward the ALU.
//  slave  : view of the fetch block (takes commands, drives reads and pairs)
//  master : view of the surrounding environment
interface elementwise_operand_fetch_if;

  // command channel
  logic                                                  cmd_valid;
  logic                                                  cmd_ready;
  logic [elementwise_operand_fetch_pkg::ADDR_WIDTH-1:0]  cmd_addr_a;
  logic [elementwise_operand_fetch_pkg::ADDR_WIDTH-1:0]  cmd_addr_b;
  logic [elementwise_operand_fetch_pkg::LEN_WIDTH-1:0]   cmd_len;
  logic [elementwise_operand_fetch_pkg::OP_WIDTH-1:0]    cmd_op;
  logic                                                  cmd_bcast_b;

  // scratchpad read port (1-cycle latency)
  logic                                                  rd_en;
  logic [elementwise_operand_fetch_pkg::ADDR_WIDTH-1:0]  rd_addr;
  logic [elementwise_operand_fetch_pkg::DATA_WIDTH-1:0]  rd_data;

  // operand-pair channel toward the ALU
  logic [elementwise_operand_fetch_pkg::DATA_WIDTH-1:0]  operand_a;
  logic [elementwise_operand_fetch_pkg::DATA_WIDTH-1:0]  operand_b;
  logic [elementwise_operand_fetch_pkg::OP_WIDTH-1:0]    op_type;
  logic                                                  valid_out;
  logic                                                  ready_out;
  logic                                                  last;
  logic                                                  done;

  modport slave (
    input  cmd_valid, cmd_addr_a, cmd_addr_b, cmd_len, cmd_op, cmd_bcast_b,
    input  rd_data, ready_out,
    output cmd_ready, rd_en, rd_addr,
    output operand_a, operand_b, op_type, valid_out, last, done
  );

  modport master (
    output cmd_valid, cmd_addr_a, cmd_addr_b, cmd_len, cmd_op, cmd_bcast_b,
    output rd_data, ready_out,
    input  cmd_ready, rd_en, rd_addr,
    input  operand_a, operand_b, op_type, valid_out, last, done
  );

endinterface

// File: rtl/elementwise_operand_fetch.sv
// Operand fetch for the element-wise ALU. Accepts one vector command, reads
// A/B operand pairs from a 1-cycle-latency single-port scratchpad and presents
// each pair with the latched op code on a registered valid/ready channel.
// Ports:
//  clk, rst_n : clock, asynchronous active-low reset
//  bus        : slave view of elementwise_operand_fetch_if (command channel,
//               scratchpad read port, operand-pair channel, done pulse)
module elementwise_operand_fetch
  import elementwise_operand_fetch_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  elementwise_operand_fetch_if.slave  bus
);

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_BRD     = 4'd1,
    ST_BCAP    = 4'd2,
    ST_RDA     = 4'd3,
    ST_RDB     = 4'd4,
    ST_CAPB    = 4'd5,
    ST_CAPA    = 4'd6,
    ST_PRESENT = 4'd7,
    ST_DONE    = 4'd8
  } state_e;

  state_e                 state;
  fetch_cmd_t             cmd_r;
  logic [LEN_WIDTH-1:0]   idx;
  logic [DATA_WIDTH-1:0]  a_reg;
  logic [DATA_WIDTH-1:0]  b_reg;
  logic                   valid_r;
  logic                   last_r;
  logic                   done_r;
  logic                   cmd_ready_r;
  logic                   rd_en_r;
  logic [ADDR_WIDTH-1:0]  rd_addr_r;

  logic [LEN_WIDTH-1:0]   idx_inc_c;
  logic                   last_c;

  assign idx_inc_c = idx + LEN_WIDTH'(1);
  // len is never 0 once an element is being fetched, so len-1 cannot wrap here
  assign last_c    = (idx == (cmd_r.len - LEN_WIDTH'(1)));

  // Control and datapath; every output comes straight from a flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cmd_r       <= '0;
      idx         <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      valid_r     <= 1'b0;
      last_r      <= 1'b0;
      done_r      <= 1'b0;
      cmd_ready_r <= 1'b1;
      rd_en_r     <= 1'b0;
      rd_addr_r   <= '0;
    end else begin
      // read strobe and done are single-cycle unless a branch re-asserts them
      done_r    <= 1'b0;
      rd_en_r   <= 1'b0;
      rd_addr_r <= '0;

      unique case (state)
        ST_IDLE: begin
          if (bus.cmd_valid && cmd_ready_r) begin
            cmd_r.addr_a  <= bus.cmd_addr_a;
            cmd_r.addr_b  <= bus.cmd_addr_b;
            cmd_r.len     <= bus.cmd_len;
            cmd_r.op      <= bus.cmd_op;
            cmd_r.bcast_b <= bus.cmd_bcast_b;
            idx           <= '0;
            cmd_ready_r   <= 1'b0;
            if (bus.cmd_len == '0) begin
              state  <= ST_DONE;
              done_r <= 1'b1;
            end else if (bus.cmd_bcast_b) begin
              state     <= ST_BRD;
              rd_en_r   <= 1'b1;
              rd_addr_r <= bus.cmd_addr_b;
            end else begin
              state     <= ST_RDA;
              rd_en_r   <= 1'b1;
              rd_addr_r <= bus.cmd_addr_a;
            end
          end
        end

        // scalar B read is in flight
        ST_BRD: state <= ST_BCAP;

        ST_BCAP: begin
          b_reg     <= bus.rd_data;
          state     <= ST_RDA;
          rd_en_r   <= 1'b1;
          rd_addr_r <= cmd_r.addr_a + ADDR_WIDTH'(idx);
        end

        // A read is in flight; broadcast skips the B read
        ST_RDA: begin
          if (cmd_r.bcast_b) begin
            state <= ST_CAPA;
          end else begin
            state     <= ST_RDB;
            rd_en_r   <= 1'b1;
            rd_addr_r <= cmd_r.addr_b + ADDR_WIDTH'(idx);
          end
        end

        ST_RDB: begin
          a_reg <= bus.rd_data;
          state <= ST_CAPB;
        end

        ST_CAPB: begin
          b_reg   <= bus.rd_data;
          valid_r <= 1'b1;
          last_r  <= last_c;
          state   <= ST_PRESENT;
        end

        ST_CAPA: begin
          a_reg   <= bus.rd_data;
          valid_r <= 1'b1;
          last_r  <= last_c;
          state   <= ST_PRESENT;
        end

        // hold the pair until the ALU takes it
        ST_PRESENT: begin
          if (bus.ready_out) begin
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            if (last_r) begin
              state  <= ST_DONE;
              done_r <= 1'b1;
            end else begin
              idx       <= idx_inc_c;
              state     <= ST_RDA;
              rd_en_r   <= 1'b1;
              rd_addr_r <= cmd_r.addr_a + ADDR_WIDTH'(idx_inc_c);
            end
          end
        end

        ST_DONE: begin
          state       <= ST_IDLE;
          cmd_ready_r <= 1'b1;
        end

        default: begin
          state       <= ST_IDLE;
          cmd_ready_r <= 1'b1;
          valid_r     <= 1'b0;
          last_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_r;
  assign bus.rd_en     = rd_en_r;
  assign bus.rd_addr   = rd_addr_r;
  assign bus.operand_a = a_reg;
  assign bus.operand_b = b_reg;
  assign bus.op_type   = cmd_r.op;
  assign bus.valid_out = valid_r;
  assign bus.last      = last_r;
  assign bus.done      = done_r;

endmodule

// File: tb/tb_elementwise_operand_fetch.sv
// Scoreboard bench for elementwise_operand_fetch: a scratchpad model, a
// reference model that builds the expected pair/address streams from memory
// contents, and a monitor that checks every read, transfer and stall cycle.
module tb_elementwise_operand_fetch;
  import elementwise_operand_fetch_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  elementwise_operand_fetch_if bus();

  elementwise_operand_fetch dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic        last;
  } pair_t;

  pair_t       exp_q[$];
  logic [11:0] addr_q[$];
  logic [15:0] mem [4096];

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  // monitor-owned running totals
  int rd_tot = 0, done_tot = 0, tr_tot = 0, v_tot = 0;
  int last_tr_cyc = 0, mon_id = 0;
  // driver-owned per-command snapshot
  int s_rd, s_done, s_tr, s_v, exp_rd;
  int cmd_id = 0;
  int mode   = 0;
  bit cur_bc = 1'b0;

  logic        p_valid = 1'b0, p_ready = 1'b0, p_last = 1'b0;
  logic [15:0] p_a = '0, p_b = '0;
  logic [2:0]  p_op = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_evt(input string name);
    n_total++;
    $display("FAIL %s: event not expected / not seen (cycle %0d)", name, cyc);
  endtask

  always @(posedge clk) cyc++;

  // scratchpad: data appears the cycle after the strobe
  always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

  // ALU ready: 0 always ready, 1 random, 2 stall the first pair of a command 5 cycles
  int hold = 0, hold_id = -1;
  always @(posedge clk) begin
    #1;
    if (hold_id != cmd_id) begin hold = 0; hold_id = cmd_id; end
    case (mode)
      0: bus.ready_out = 1'b1;
      1: bus.ready_out = 1'($urandom_range(0, 1));
      default: begin
        if (bus.valid_out && hold < 5) begin bus.ready_out = 1'b0; hold++; end
        else bus.ready_out = 1'b1;
      end
    endcase
  end

  // monitor
  always @(negedge clk) begin
    pair_t e;
    if (!rst_n) begin
      p_valid = 1'b0;
      p_ready = 1'b0;
    end else begin
      if (p_valid && !p_ready) begin
        chk("hold_valid", 64'(bus.valid_out), 64'(1));
        chk("hold_a",     64'(bus.operand_a), 64'(p_a));
        chk("hold_b",     64'(bus.operand_b), 64'(p_b));
        chk("hold_op",    64'(bus.op_type),   64'(p_op));
        chk("hold_last",  64'(bus.last),      64'(p_last));
      end
      if (bus.rd_en) begin
        rd_tot++;
        if (addr_q.size() == 0) fail_evt("rd_unexpected");
        else chk("rd_addr", 64'(bus.rd_addr), 64'(addr_q.pop_front()));
      end else begin
        chk("rd_addr_idle", 64'(bus.rd_addr), 64'(0));
      end
      if (bus.valid_out) begin
        v_tot++;
        chk("rd_while_valid", 64'(bus.rd_en), 64'(0));
      end
      if (bus.done) begin
        done_tot++;
        chk("valid_at_done", 64'(bus.valid_out), 64'(0));
      end
      if (bus.valid_out === 1'b1 && bus.ready_out === 1'b1) begin
        if (exp_q.size() == 0) fail_evt("pair_unexpected");
        else begin
          e = exp_q.pop_front();
          chk("pair_a",    64'(bus.operand_a), 64'(e.a));
          chk("pair_b",    64'(bus.operand_b), 64'(e.b));
          chk("pair_op",   64'(bus.op_type),   64'(e.op));
          chk("pair_last", 64'(bus.last),      64'(e.last));
        end
        if (mode == 0 && mon_id == cmd_id)
          chk("pair_spacing", 64'(cyc - last_tr_cyc), cur_bc ? 64'(3) : 64'(4));
        mon_id      = cmd_id;
        last_tr_cyc = cyc;
        tr_tot++;
      end
      p_valid = bus.valid_out;
      p_ready = bus.ready_out;
      p_a     = bus.operand_a;
      p_b     = bus.operand_b;
      p_op    = bus.op_type;
      p_last  = bus.last;
    end
  end

  // Reference model + command handshake
  task automatic issue_cmd(input logic [11:0] a, input logic [11:0] b, input logic [11:0] len,
                           input logic [2:0] op, input bit bc);
    pair_t       p;
    logic [11:0] aa;
    int          ca;
    bit          seen;
    cmd_id++;
    cur_bc = bc;
    if (bc && len != 0) addr_q.push_back(b);
    for (int i = 0; i < int'(len); i++) begin
      aa     = a + 12'(i);
      p.a    = mem[aa];
      p.b    = bc ? mem[b] : mem[12'(b + 12'(i))];
      p.op   = op;
      p.last = (i == int'(len) - 1);
      exp_q.push_back(p);
      addr_q.push_back(aa);
      if (!bc) addr_q.push_back(12'(b + 12'(i)));
    end
    exp_rd = (len == 0) ? 0 : (bc ? int'(len) + 1 : 2 * int'(len));
    s_rd = rd_tot; s_done = done_tot; s_tr = tr_tot; s_v = v_tot;

    @(posedge clk); #1;
    bus.cmd_valid   = 1'b1;
    bus.cmd_addr_a  = a;
    bus.cmd_addr_b  = b;
    bus.cmd_len     = len;
    bus.cmd_op      = op;
    bus.cmd_bcast_b = bc;
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin seen = 1'b1; break; end
    end
    if (!seen) fail_evt("cmd_ready_timeout");
    @(posedge clk); #1;
    ca = cyc;
    // keep a garbage command on the bus while busy; it must be ignored
    bus.cmd_valid   = (len != 0);
    bus.cmd_addr_a  = 12'($urandom);
    bus.cmd_addr_b  = 12'($urandom);
    bus.cmd_len     = 12'($urandom);
    bus.cmd_op      = 3'($urandom);
    bus.cmd_bcast_b = 1'($urandom);
    if (len != 0) begin
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (bus.valid_out) begin seen = 1'b1; break; end
      end
      if (!seen) fail_evt("valid_timeout");
      else if (!bc) chk("first_valid_latency", 64'(cyc - ca), 64'(3));
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input int len, input int bound);
    bit seen = 1'b0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (done_tot != s_done) begin seen = 1'b1; break; end
    end
    if (!seen) fail_evt("done_timeout");
    repeat (4) @(negedge clk);
    chk("done_pulses", 64'(done_tot - s_done), 64'(1));
    chk("pairs_left",  64'(exp_q.size()),      64'(0));
    chk("reads_left",  64'(addr_q.size()),     64'(0));
    chk("rd_count",    64'(rd_tot - s_rd),     64'(exp_rd));
    chk("transfers",   64'(tr_tot - s_tr),     64'(len));
    if (len == 0) chk("valid_len0", 64'(v_tot - s_v), 64'(0));
    chk("cmd_ready_idle", 64'(bus.cmd_ready), 64'(1));
    exp_q.delete();
    addr_q.delete();
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'(1));
    chk({tag, "_valid"},     64'(bus.valid_out), 64'(0));
    chk({tag, "_done"},      64'(bus.done),      64'(0));
    chk({tag, "_rd_en"},     64'(bus.rd_en),     64'(0));
    chk({tag, "_rd_addr"},   64'(bus.rd_addr),   64'(0));
    chk({tag, "_last"},      64'(bus.last),      64'(0));
    chk({tag, "_op_a"},      64'(bus.operand_a), 64'(0));
    chk({tag, "_op_b"},      64'(bus.operand_b), 64'(0));
    chk({tag, "_op_type"},   64'(bus.op_type),   64'(0));
  endtask

  initial begin
    logic [11:0] rl;
    bit          seen;
    rst_n           = 1'b0;
    bus.cmd_valid   = 1'b0;
    bus.cmd_addr_a  = '0;
    bus.cmd_addr_b  = '0;
    bus.cmd_len     = '0;
    bus.cmd_op      = '0;
    bus.cmd_bcast_b = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst_n = 1'b1;

    // basic three-element command
    mem[12'h010] = 16'd1;  mem[12'h011] = 16'd2;  mem[12'h012] = 16'd3;
    mem[12'h020] = 16'd10; mem[12'h021] = 16'd20; mem[12'h022] = 16'd30;
    mode = 0;
    issue_cmd(12'h010, 12'h020, 12'd3, 3'd0, 1'b0);
    wait_done(3, 100);

    // broadcast scalar B
    mem[12'h040] = 16'd7;
    issue_cmd(12'h300, 12'h040, 12'd4, 3'd2, 1'b1);
    wait_done(4, 100);

    // zero-length command
    issue_cmd(12'h123, 12'h456, 12'd0, 3'd1, 1'b0);
    wait_done(0, 20);

    // ALU back-pressure for 5 cycles
    mode = 2;
    issue_cmd(12'h500, 12'h600, 12'd2, 3'd5, 1'b0);
    wait_done(2, 100);

    // address wrap
    mode = 0;
    issue_cmd(12'hFFE, 12'h7F0, 12'd4, 3'd1, 1'b0);
    wait_done(4, 100);

    // reset mid-command after the second transfer, then a clean restart
    issue_cmd(12'h080, 12'h0C0, 12'd6, 3'd4, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (tr_tot - s_tr >= 2) begin seen = 1'b1; break; end
    end
    if (!seen) fail_evt("second_transfer_timeout");
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("midreset");
    exp_q.delete();
    addr_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("no_done_on_reset", 64'(done_tot - s_done), 64'(0));
    issue_cmd(12'h080, 12'h0C0, 12'd3, 3'd4, 1'b0);
    wait_done(3, 100);

    // randomized commands
    for (int t = 0; t < 25; t++) begin
      mode = int'($urandom_range(0, 1));
      rl   = 12'($urandom_range(0, 9));
      issue_cmd(12'($urandom), 12'($urandom), rl, 3'($urandom), 1'($urandom));
      wait_done(int'(rl), 12 * int'(rl) + 60);
    end

    // maximum length
    mode = 0;
    issue_cmd(12'($urandom), 12'($urandom), 12'hFFF, 3'd6, 1'b0);
    wait_done(4095, 4 * 4095 + 100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
